// File: rtl/morse_key_decoder.sv
// ---------------------------------------------------------------------------
// morse_key_decoder
//
// Turns a raw Morse key level into a stream of 2-bit symbols. Each run of the
// key (tone or silence) is measured in Morse units: a prescaler divides clk
// down to a unit tick, and a saturating counter counts ticks since the last
// key edge.
//
// Symbols:
//   00 dot        : mark lasting exactly 1 unit
//   01 dash       : mark lasting 2 or more units
//   10 letter gap : space of 2..4 units, reported when the next mark starts
//   11 word gap   : space reaching 5 units, reported as soon as it gets there
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   div        clk cycles per Morse unit (0 behaves as 1)
//   key_in     raw key level, 1 = tone; asynchronous to clk
//   sym_ready  consumer takes the held symbol this cycle
//   sym_valid  sym holds an unconsumed symbol
//   sym        symbol code (see above)
//   overrun    sticky: a symbol was produced while the previous one was held
// ---------------------------------------------------------------------------
module morse_key_decoder #(
  parameter int WID = 5,
  parameter int CW  = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WID-1:0] div,
  input  logic           key_in,
  input  logic           sym_ready,
  output logic           sym_valid,
  output logic [1:0]     sym,
  output logic           overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [CW-1:0] RUN_DOT  = CW'(1);
  localparam logic [CW-1:0] RUN_LGAP = CW'(2);
  localparam logic [CW-1:0] RUN_WGAP = CW'(5);

  // Saturating increment of the run counter: parks at all-ones.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // A divide of zero would never tick; treat it as one cycle per unit.
  function automatic logic [WID-1:0] unit_of(input logic [WID-1:0] d);
    return (d == '0) ? WID'(1) : d;
  endfunction

  logic           key_m;
  logic           key_s;
  logic           key_d;
  logic [1:0]     prime;
  logic [WID-1:0] unit_len;
  logic [WID-1:0] pre_cnt;
  logic [CW-1:0]  run_cnt;
  logic [1:0]     state;
  logic           armed;
  logic           wgap_done;

  logic           primed;
  logic           edge_ok;
  logic           rise;
  logic           fall;
  logic           tick;
  logic [CW-1:0]  run_now;

  logic [1:0]     state_nx;
  logic           armed_nx;
  logic           wgap_nx;
  logic           new_vld;
  logic [1:0]     new_sym;

  // ---- input synchronizer and edge detect ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
      prime <= 2'd0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
      key_d <= key_s;
      if (prime != 2'd3)
        prime <= prime + 2'd1;
    end
  end

  // The synchronizer holds reset values for three cycles after release.
  // Edges inside that window are artefacts of reset, not real key
  // transitions; ignoring them means a key held down across reset never
  // counts as a fresh mark.
  assign primed  = (prime == 2'd3);
  assign edge_ok = primed && (key_s != key_d);
  assign rise    = edge_ok &&  key_s;
  assign fall    = edge_ok && !key_s;

  // ---- unit prescaler and run-length counter ----
  assign tick = (pre_cnt == unit_len - WID'(1));

  // Run length as it stands at the end of this cycle, so a tick landing on
  // the same cycle as an edge still completes its unit.
  assign run_now = tick ? sat_inc(run_cnt) : run_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      unit_len <= WID'(1);
      run_cnt  <= '0;
    end else if (edge_ok) begin
      pre_cnt  <= '0;
      unit_len <= unit_of(div);
      run_cnt  <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
      unit_len <= unit_of(div);
      run_cnt  <= sat_inc(run_cnt);
    end else begin
      pre_cnt  <= pre_cnt + WID'(1);
    end
  end

  // ---- classification FSM ----
  always_comb begin
    state_nx = state;
    armed_nx = armed;
    wgap_nx  = wgap_done;
    new_vld  = 1'b0;
    new_sym  = SYM_DOT;

    // Every edge starts a new run, so the word-gap latch only covers the
    // space currently being measured.
    if (edge_ok)
      wgap_nx = 1'b0;

    case (state)
      IDLE: begin
        if (rise)
          state_nx = MARK;
      end

      MARK: begin
        if (fall) begin
          if (run_now != '0) begin
            new_vld  = 1'b1;
            new_sym  = (run_now == RUN_DOT) ? SYM_DOT : SYM_DASH;
            armed_nx = 1'b1;
            state_nx = SPACE;
          end else begin
            // Glitch: discarded, and it leaves the arming untouched.
            state_nx = armed ? SPACE : IDLE;
          end
        end
      end

      SPACE: begin
        if (rise) begin
          state_nx = MARK;
          if (!wgap_done) begin
            if (run_now >= RUN_WGAP) begin
              // The fifth unit closed on the rising-edge cycle itself.
              new_vld = 1'b1;
              new_sym = SYM_WGAP;
            end else if (run_now >= RUN_LGAP) begin
              new_vld = 1'b1;
              new_sym = SYM_LGAP;
            end
          end
        end else if (tick && !wgap_done && run_now == RUN_WGAP) begin
          new_vld = 1'b1;
          new_sym = SYM_WGAP;
          wgap_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      wgap_done <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= armed_nx;
      wgap_done <= wgap_nx;
    end
  end

  // ---- output holding register ----
  // A held, unaccepted symbol is never overwritten; the newcomer is lost
  // and overrun latches until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_valid <= 1'b0;
      sym       <= SYM_DOT;
      overrun   <= 1'b0;
    end else begin
      if (new_vld) begin
        if (!sym_valid || sym_ready) begin
          sym_valid <= 1'b1;
          sym       <= new_sym;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_key_decoder
//
// Directed bench for morse_key_decoder with div = 5 (one unit = 5 clk).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point. A key transition made just after edge P shows up as a symbol
// after edge P+3 (two synchronizer flops plus the output register).
// ---------------------------------------------------------------------------
module tb_morse_key_decoder;

  logic       clk;
  logic       reset;
  logic [4:0] div;
  logic       key_in;
  logic       sym_ready;
  logic       sym_valid;
  logic [1:0] sym;
  logic       overrun;

  int vectors;
  int miscompares;

  morse_key_decoder #(.WID(5), .CW(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .key_in    (key_in),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid),
    .sym       (sym),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full check of all three outputs.
  task automatic chk(input string tag, input logic v, input logic [1:0] s,
                     input logic o);
    vectors++;
    assert (sym_valid === v && sym === s && overrun === o)
    else begin
      miscompares++;
      $error("FAIL %s: observed valid=%b sym=%b ovr=%b, expected valid=%b sym=%b ovr=%b",
             tag, sym_valid, sym, overrun, v, s, o);
    end
  endtask

  // No symbol pending; sym itself is don't-care.
  task automatic chk_none(input string tag, input logic o);
    vectors++;
    assert (sym_valid === 1'b0 && overrun === o)
    else begin
      miscompares++;
      $error("FAIL %s: observed valid=%b ovr=%b, expected valid=0 ovr=%b",
             tag, sym_valid, overrun, o);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    div         = 5'd5;
    key_in      = 1'b0;
    sym_ready   = 1'b1;

    // Reset asserted before any clock edge
    #2 reset = 1'b0;
    #1 chk("reset_async", 1'b0, 2'b00, 1'b0);
    tick(3);
    chk("reset_held", 1'b0, 2'b00, 1'b0);
    reset = 1'b1;
    tick(4);

    // Dot: 5 cycles of tone = 1 unit
    key_in = 1'b1; tick(5); key_in = 1'b0;          // fall at X
    tick(2); chk_none("dot_early", 1'b0);
    tick(1); chk("dot", 1'b1, 2'b00, 1'b0);
    tick(1); chk_none("dot_consumed", 1'b0);

    // 12-cycle space = 2 units -> letter gap at the rise
    tick(8); key_in = 1'b1;                         // rise at X+12
    tick(2); chk_none("lgap_early", 1'b0);
    tick(1); chk("lgap", 1'b1, 2'b10, 1'b0);
    tick(1); chk_none("lgap_consumed", 1'b0);

    // Same mark runs 15 cycles = 3 units -> dash
    tick(11); key_in = 1'b0;
    tick(3); chk("dash", 1'b1, 2'b01, 1'b0);
    tick(1); chk_none("dash_consumed", 1'b0);

    // 7-cycle space = 1 unit -> no gap symbol
    tick(3); key_in = 1'b1;
    tick(3); chk_none("short_space_a", 1'b0);
    tick(1); chk_none("short_space_b", 1'b0);

    // Dash, then a 30-cycle space: word gap 25 cycles after the fall
    tick(11); key_in = 1'b0;                        // fall at V
    tick(3); chk("dash2", 1'b1, 2'b01, 1'b0);
    tick(1);
    tick(23); chk_none("wgap_early", 1'b0);          // V+27
    tick(1); chk("wgap", 1'b1, 2'b11, 1'b0);         // V+28
    tick(1); chk_none("wgap_once", 1'b0);
    tick(1); key_in = 1'b1;                          // rise at V+30 = U
    tick(3); chk_none("no_lgap_after_wgap", 1'b0);
    tick(1); chk_none("no_lgap_after_wgap2", 1'b0);

    // Consumer stalls: dot is held, a following dash is dropped
    sym_ready = 1'b0;
    tick(1); key_in = 1'b0;                          // 5-cycle mark -> dot
    tick(3); chk("hold_dot", 1'b1, 2'b00, 1'b0);
    tick(1); chk("hold_dot_stays", 1'b1, 2'b00, 1'b0);
    tick(3); key_in = 1'b1;                          // 7-cycle space
    tick(4); chk("hold_dot_space", 1'b1, 2'b00, 1'b0);
    tick(11); key_in = 1'b0;                         // 15-cycle mark, fall at C
    tick(2); chk("pre_overrun", 1'b1, 2'b00, 1'b0);
    tick(1); chk("overrun", 1'b1, 2'b00, 1'b1);      // C+3
    sym_ready = 1'b1;
    tick(1); chk_none("drained", 1'b1);              // C+4

    // Reset pulsed in the middle of a 15-cycle mark
    key_in = 1'b1;                                   // mark starts at C+4
    tick(6);
    #2 reset = 1'b0;
    #1 chk("reset_mid_mark", 1'b0, 2'b00, 1'b0);
    tick(2); chk("reset_mid_mark_held", 1'b0, 2'b00, 1'b0);
    reset = 1'b1;
    tick(7); key_in = 1'b0;                          // fall at C+19
    tick(3); chk_none("post_reset_fall", 1'b0);
    tick(1); chk_none("post_reset_fall2", 1'b0);
    tick(1); chk_none("post_reset_fall3", 1'b0);

    // 3-cycle glitch while unarmed, then 12-cycle low: nothing at all
    key_in = 1'b1; tick(3); key_in = 1'b0;
    tick(3); chk_none("glitch", 1'b0);
    tick(1); chk_none("glitch2", 1'b0);
    tick(8); key_in = 1'b1;
    tick(3); chk_none("no_gap_unarmed", 1'b0);
    tick(1); chk_none("no_gap_unarmed2", 1'b0);

    // A real dot still decodes afterwards
    tick(1); key_in = 1'b0;
    tick(3); chk("rearm_dot", 1'b1, 2'b00, 1'b0);
    tick(1); chk_none("rearm_dot_consumed", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
